// File: rtl/usb_fs_tx_pkt_framer.sv
// USB full-speed transmit framer: PID, payload and CRC16 byte stream
// handed to the bit serializer over a valid/ready handshake.
module usb_fs_tx_pkt_framer #(
    parameter int MaxPktSizeByte = 64,
    localparam int CntW = $clog2(MaxPktSizeByte) + 1
) (
    input  logic       clk_48mhz_i,
    input  logic       rst_ni,
    input  logic       link_reset_i,
    input  logic       tx_pkt_start_i,
    input  logic [3:0] tx_pid_i,
    input  logic       tx_data_avail_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_data_get_o,
    output logic       tx_pkt_end_o,
    output logic       byte_valid_o,
    input  logic       byte_ready_i,
    output logic [7:0] byte_o,
    output logic       byte_sop_o,
    output logic       byte_eop_o,
    input  logic       line_eop_done_i,
    output logic       busy_o,
    output logic       err_start_busy_o,
    output logic       err_trunc_o
);

    typedef enum logic [2:0] {
        StIdle,
        StPid,
        StData,
        StCrc,
        StCrc1,
        StWaitEop
    } state_e;

    state_e            state_q;
    logic [7:0]        byte_q;
    logic              valid_q;
    logic              sop_q;
    logic              eop_q;
    logic              is_data_q;
    logic [15:0]       crc_q;
    logic [CntW-1:0]   cnt_q;
    logic [1:0]        gap_q;
    logic              get_q;
    logic              end_q;
    logic              err_start_q;
    logic              err_trunc_q;

    logic xfer;
    logic slot_free;
    logic room;

    assign xfer      = valid_q && byte_ready_i;
    assign slot_free = !valid_q || byte_ready_i;
    assign room      = cnt_q < CntW'(MaxPktSizeByte);

    // Reflected CRC16 (0xA001), one byte LSB-first.
    function automatic logic [15:0] crc_upd(
        input logic [15:0] c_in,
        input logic [7:0]  d
    );
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 16'hA001;
        end
        return c;
    endfunction

    always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            byte_q      <= 8'h00;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            is_data_q   <= 1'b0;
            crc_q       <= 16'hFFFF;
            cnt_q       <= '0;
            gap_q       <= 2'd0;
            get_q       <= 1'b0;
            end_q       <= 1'b0;
            err_start_q <= 1'b0;
            err_trunc_q <= 1'b0;
        end else begin
            get_q       <= 1'b0;
            end_q       <= 1'b0;
            err_start_q <= 1'b0;
            err_trunc_q <= 1'b0;
            if (gap_q != 2'd0) gap_q <= gap_q - 2'd1;
            if (link_reset_i) begin
                state_q <= StIdle;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
                crc_q   <= 16'hFFFF;
                cnt_q   <= '0;
                gap_q   <= 2'd0;
            end else begin
                if (tx_pkt_start_i && state_q != StIdle)
                    err_start_q <= 1'b1;
                unique case (state_q)
                    StIdle: begin
                        if (tx_pkt_start_i) begin
                            byte_q    <= {~tx_pid_i, tx_pid_i};
                            valid_q   <= 1'b1;
                            sop_q     <= 1'b1;
                            eop_q     <= tx_pid_i[1:0] != 2'b11;
                            is_data_q <= tx_pid_i[1:0] == 2'b11;
                            crc_q     <= 16'hFFFF;
                            cnt_q     <= '0;
                            gap_q     <= 2'd0;
                            state_q   <= StPid;
                        end
                    end
                    StPid: begin
                        if (xfer) begin
                            valid_q <= 1'b0;
                            sop_q   <= 1'b0;
                            eop_q   <= 1'b0;
                            state_q <= is_data_q ? StData : StWaitEop;
                        end
                    end
                    StData: begin
                        if (slot_free) begin
                            valid_q <= 1'b0;
                            // Engine data is only trusted once the gap expires.
                            if (gap_q == 2'd0) begin
                                valid_q <= 1'b1;
                                if (tx_data_avail_i && room) begin
                                    byte_q <= tx_data_i;
                                    get_q  <= 1'b1;
                                    crc_q  <= crc_upd(crc_q, tx_data_i);
                                    cnt_q  <= cnt_q + CntW'(1);
                                    gap_q  <= 2'd2;
                                end else begin
                                    byte_q      <= ~crc_q[7:0];
                                    err_trunc_q <= tx_data_avail_i;
                                    state_q     <= StCrc;
                                end
                            end
                        end
                    end
                    StCrc: begin
                        if (xfer) begin
                            byte_q  <= ~crc_q[15:8];
                            eop_q   <= 1'b1;
                            state_q <= StCrc1;
                        end
                    end
                    StCrc1: begin
                        if (xfer) begin
                            valid_q <= 1'b0;
                            eop_q   <= 1'b0;
                            state_q <= StWaitEop;
                        end
                    end
                    StWaitEop: begin
                        if (line_eop_done_i) begin
                            end_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign tx_data_get_o    = get_q;
    assign tx_pkt_end_o     = end_q;
    assign byte_valid_o     = valid_q;
    assign byte_o           = byte_q;
    assign byte_sop_o       = sop_q;
    assign byte_eop_o       = eop_q;
    assign busy_o           = state_q != StIdle;
    assign err_start_busy_o = err_start_q;
    assign err_trunc_o      = err_trunc_q;

endmodule

// File: tb/tb_usb_fs_tx_pkt_framer.sv
// Randomized scoreboard bench for usb_fs_tx_pkt_framer: a reference
// model queues expected bytes, a negedge monitor pops and compares.
module tb_usb_fs_tx_pkt_framer;

    localparam int MaxB = 64;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       link_reset_i = 1'b0;
    logic       tx_pkt_start_i = 1'b0;
    logic [3:0] tx_pid_i = 4'h0;
    logic       tx_data_avail_i;
    logic [7:0] tx_data_i;
    logic       tx_data_get_o;
    logic       tx_pkt_end_o;
    logic       byte_valid_o;
    logic       byte_ready_i = 1'b0;
    logic [7:0] byte_o;
    logic       byte_sop_o;
    logic       byte_eop_o;
    logic       line_eop_done_i = 1'b0;
    logic       busy_o;
    logic       err_start_busy_o;
    logic       err_trunc_o;

    usb_fs_tx_pkt_framer #(.MaxPktSizeByte(MaxB)) dut (
        .clk_48mhz_i     (clk),
        .rst_ni          (rst_ni),
        .link_reset_i    (link_reset_i),
        .tx_pkt_start_i  (tx_pkt_start_i),
        .tx_pid_i        (tx_pid_i),
        .tx_data_avail_i (tx_data_avail_i),
        .tx_data_i       (tx_data_i),
        .tx_data_get_o   (tx_data_get_o),
        .tx_pkt_end_o    (tx_pkt_end_o),
        .byte_valid_o    (byte_valid_o),
        .byte_ready_i    (byte_ready_i),
        .byte_o          (byte_o),
        .byte_sop_o      (byte_sop_o),
        .byte_eop_o      (byte_eop_o),
        .line_eop_done_i (line_eop_done_i),
        .busy_o          (busy_o),
        .err_start_busy_o(err_start_busy_o),
        .err_trunc_o     (err_trunc_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;

    // Engine model: byte stream indexed by eng_idx, advanced per get.
    logic [7:0] eng_buf [0:127];
    int eng_len = 0;
    int eng_idx = 0;
    assign tx_data_avail_i = eng_idx < eng_len;
    assign tx_data_i = (eng_idx < eng_len) ? eng_buf[eng_idx] : 8'h00;

    logic [9:0] exp_q [$];
    int xfer_cnt = 0;
    int get_cnt = 0;
    int end_cnt = 0;
    int trunc_cnt = 0;
    int serr_cnt = 0;
    int gap_bad = 0;
    int cyc = 0;
    int last_get = -100;
    bit rnd_ready = 1'b0;
    bit hold_low = 1'b0;
    int hold_at = 0;

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 8; b++)
                if ((c[0] ^ eng_buf[k][b]) == 1'b1)
                    c = (c >> 1) ^ 16'hA001;
                else
                    c = c >> 1;
        return c;
    endfunction

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_low && xfer_cnt >= hold_at)
                byte_ready_i = 1'b0;
            else if (rnd_ready)
                byte_ready_i = ($urandom_range(0, 2) != 0);
            else
                byte_ready_i = rst_ni;
        end
    end

    // Monitor: scoreboard pops, hold-stability, pulse counters.
    initial begin
        logic       pstall;
        logic [9:0] pval;
        logic       plr;
        logic [9:0] got;
        pstall = 1'b0;
        pval = '0;
        plr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                got = {byte_sop_o, byte_eop_o, byte_o};
                if (pstall && !plr) begin
                    check("hold_valid", int'(byte_valid_o), 1);
                    check("hold_byte", int'(got), int'(pval));
                end
                if (byte_valid_o && byte_ready_i) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0)
                        check("unexpected_byte", int'(got), -1);
                    else
                        check("byte", int'(got), int'(exp_q.pop_front()));
                end
                if (tx_data_get_o) begin
                    get_cnt++;
                    if (cyc - last_get < 3) gap_bad++;
                    last_get = cyc;
                    eng_idx++;
                end
                if (tx_pkt_end_o) end_cnt++;
                if (err_trunc_o) trunc_cnt++;
                if (err_start_busy_o) serr_cnt++;
                pstall = byte_valid_o && !byte_ready_i;
                pval = got;
                plr = link_reset_i;
            end else begin
                pstall = 1'b0;
            end
        end
    end

    task automatic push_expected(input logic [3:0] pid);
        int n;
        logic [15:0] c;
        exp_q.push_back({1'b1, pid[1:0] != 2'b11, ~pid, pid});
        if (pid[1:0] == 2'b11) begin
            n = (eng_len > MaxB) ? MaxB : eng_len;
            for (int k = 0; k < n; k++)
                exp_q.push_back({2'b00, eng_buf[k]});
            c = ~crc_model(n);
            exp_q.push_back({2'b00, c[7:0]});
            exp_q.push_back({2'b01, c[15:8]});
        end
    endtask

    task automatic pulse_start(input logic [3:0] pid, input bit stray);
        @(posedge clk);
        #1;
        tx_pkt_start_i = 1'b1;
        tx_pid_i = pid;
        line_eop_done_i = stray;
        @(posedge clk);
        #1;
        tx_pkt_start_i = 1'b0;
        line_eop_done_i = 1'b0;
    endtask

    task automatic run_pkt(input string nm, input logic [3:0] pid,
                           input bit midstart, input bit stray);
        int g0, e0, t0, s0, w, n;
        n = (pid[1:0] != 2'b11) ? 0 : ((eng_len > MaxB) ? MaxB : eng_len);
        g0 = get_cnt; e0 = end_cnt; t0 = trunc_cnt; s0 = serr_cnt;
        gap_bad = 0;
        eng_idx = 0;
        push_expected(pid);
        check({nm, "_idle"}, int'(busy_o), 0);
        pulse_start(pid, stray);
        check({nm, "_lat_valid"}, int'(byte_valid_o), 1);
        check({nm, "_lat_sop"}, int'(byte_sop_o), 1);
        if (midstart) begin
            w = 0;
            while (get_cnt - g0 < 3 && w < 500) begin
                @(posedge clk);
                w++;
            end
            pulse_start(4'h3, 1'b0);
        end
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge clk);
            w++;
        end
        check({nm, "_drain_left"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_waiteop_busy"}, int'(busy_o), 1);
        check({nm, "_no_early_end"}, end_cnt - e0, 0);
        line_eop_done_i = 1'b1;
        @(posedge clk);
        #1;
        line_eop_done_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({nm, "_end"}, end_cnt - e0, 1);
        check({nm, "_busy_after"}, int'(busy_o), 0);
        check({nm, "_gets"}, get_cnt - g0, n);
        check({nm, "_gap"}, gap_bad, 0);
        check({nm, "_trunc"}, trunc_cnt - t0, (pid[1:0] == 2'b11 && eng_len > MaxB) ? 1 : 0);
        check({nm, "_start_err"}, serr_cnt - s0, midstart ? 1 : 0);
    endtask

    initial begin
        int w, g0, e0;
        logic [15:0] c;
        #2;
        check("rst_valid", int'(byte_valid_o), 0);
        check("rst_byte", int'(byte_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_pulses", int'({tx_data_get_o, tx_pkt_end_o,
              err_trunc_o, err_start_busy_o, byte_sop_o, byte_eop_o}), 0);
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        // NAK with a stray line_eop_done in the same cycle as start.
        eng_len = 0;
        run_pkt("nak", 4'hA, 1'b0, 1'b1);

        eng_len = 0;
        run_pkt("zlp_data1", 4'hB, 1'b0, 1'b0);

        for (int k = 0; k < 9; k++) eng_buf[k] = 8'h31 + 8'(k);
        eng_len = 9;
        c = ~crc_model(9);
        check("crc_ref_check", int'(c), 16'hB4C8);
        rnd_ready = 1'b1;
        run_pkt("data0_123", 4'h3, 1'b0, 1'b0);

        for (int k = 0; k < 70; k++) eng_buf[k] = 8'($urandom);
        eng_len = 70;
        run_pkt("trunc70", 4'hB, 1'b0, 1'b0);

        for (int p = 0; p < 4; p++) begin
            eng_len = $urandom_range(1, 20);
            for (int k = 0; k < eng_len; k++) eng_buf[k] = 8'($urandom);
            run_pkt("rand", (p % 2 == 0) ? 4'h3 : 4'hB, 1'b0, 1'b0);
        end

        eng_len = 12;
        for (int k = 0; k < 12; k++) eng_buf[k] = 8'($urandom);
        run_pkt("midstart", 4'h3, 1'b1, 1'b0);

        // Link reset while crc byte 0 is stalled.
        eng_len = 5;
        for (int k = 0; k < 5; k++) eng_buf[k] = 8'($urandom);
        eng_idx = 0;
        c = ~crc_model(5);
        push_expected(4'h3);
        g0 = get_cnt;
        e0 = end_cnt;
        hold_at = xfer_cnt + 6;
        hold_low = 1'b1;
        pulse_start(4'h3, 1'b0);
        w = 0;
        while (xfer_cnt < hold_at && w < 1000) begin
            @(posedge clk);
            w++;
        end
        check("lr_reach_crc", int'(xfer_cnt >= hold_at), 1);
        repeat (5) @(posedge clk);
        #1;
        check("lr_crc0_valid", int'(byte_valid_o), 1);
        check("lr_crc0_byte", int'(byte_o), int'(c[7:0]));
        link_reset_i = 1'b1;
        @(posedge clk);
        #1;
        link_reset_i = 1'b0;
        check("lr_valid_drop", int'(byte_valid_o), 0);
        check("lr_busy_drop", int'(busy_o), 0);
        exp_q.delete();
        hold_low = 1'b0;
        line_eop_done_i = 1'b1;
        @(posedge clk);
        #1;
        line_eop_done_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("lr_no_end", end_cnt - e0, 0);
        check("lr_gets", get_cnt - g0, 5);
        eng_len = 0;
        run_pkt("nak_after_lr", 4'hA, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a payload.
        eng_len = 20;
        for (int k = 0; k < 20; k++) eng_buf[k] = 8'($urandom);
        eng_idx = 0;
        push_expected(4'h3);
        g0 = get_cnt;
        pulse_start(4'h3, 1'b0);
        w = 0;
        while (get_cnt - g0 < 4 && w < 500) begin
            @(posedge clk);
            w++;
        end
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_outs", int'({byte_valid_o, busy_o, byte_sop_o,
              byte_eop_o, tx_data_get_o, tx_pkt_end_o}), 0);
        check("arst_byte", int'(byte_o), 0);
        exp_q.delete();
        eng_len = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        run_pkt("nak_after_arst", 4'hA, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
